ksort_ctrl: RTL and testbench
=============================

KSORT_CTRL -- requirements
Module: ksort_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, value width of the sorter datapath.
REQ-002 SHALL have parameter MAX_MEMORY, default 128, depth of the attached sorter.
REQ-003 SHALL have ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a query; sampled only in IDLE.
- k_cfg  in  32  number of nearest results requested; latched on accepted start.
- in_valid  in  1  upstream value valid.
- in_ready  out  1  upstream value accepted when in_valid & in_ready.
- in_data  in  DATA_WIDTH  upstream value (distance).
- in_last  in  1  marks the final upstream value of the query.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result when out_valid & out_ready.
- out_name  out  32  result entry ID (arrival index).
- out_value  out  DATA_WIDTH  result value.
- out_last  out  1  marks the final result.
- busy  out  1  high in every state except IDLE.
- cfg_err  out  1  sticky; set by a start with k_cfg == 0.
- srt_reset  out  1  active-high synchronous clear to the sorter.
- srt_wr_en, srt_valid  out  1 each  sorter insert strobes.
- srt_rd_en, srt_done  out  1 each  sorter read-advance strobes.
- srt_k  out  32  latched k to the sorter.
- srt_data  out  DATA_WIDTH  value to the sorter; equals in_data.
- srt_name_in  in  32  sorter name at its read pointer.
- srt_value_in  in  DATA_WIDTH  sorter value at its read pointer.

Function
REQ-004 SHALL implement states IDLE, CLR, LOAD, READ, ADV1, ADV2.
REQ-005 IDLE: start & k_cfg != 0 -> CLR, latching k_cfg. start & k_cfg == 0 -> set cfg_err and remain in IDLE. cfg_err clears only on reset.
REQ-006 CLR: lasts exactly one cycle with srt_reset = 1, clears the 32-bit loaded-count n, then -> LOAD.
REQ-007 LOAD: in_ready = 1; srt_wr_en = srt_valid = in_valid (combinational).
- Each accepted value increments n, saturating at 2^32-1.
- Accepted in_last -> READ on the next edge.
REQ-008 The sorter holds ascending values; each insert overwrites one slot per cycle, so back-to-back accepts at one value per cycle SHALL be supported with no bubble.
REQ-009 Result count m = min(n, k, MAX_MEMORY), computed on entry to READ. The result index r SHALL be reset to 0 on entry to READ.
REQ-010 If m == 0 (only possible if in_last was never accompanied by data — see REQ-011), the block SHALL go -> IDLE with no result issued.
REQ-011 in_last accepted with its data counts that data. n == 0 is impossible once in_last is accepted, so REQ-010 is unreachable; it is kept as a guard.
REQ-012 READ behaviour:
- out_valid = 1; out_name = srt_name_in; out_value = srt_value_in; out_last = (r == m-1).
- srt_done = 1.
- On handshake with r == m-1 -> IDLE.
- On handshake otherwise -> ADV1 with r incremented.
- out_* SHALL be held stable while out_ready = 0.
REQ-013 ADV1 and ADV2 SHALL each assert srt_done = srt_rd_en = 1 for one cycle, with out_valid = 0, then -> ADV2 and -> READ respectively.
- The sorter advances its pointer once per two read strobes, so each result costs 3 cycles minimum.
REQ-014 srt_k SHALL equal the latched k in all states; srt_done = 0 outside READ/ADV1/ADV2; srt_rd_en = 0 outside ADV1/ADV2.
REQ-015 in_valid is ignored outside LOAD. start is ignored outside IDLE. out_ready is ignored outside READ.
REQ-016 Latency from accepted in_last to first out_valid SHALL be 1 cycle.

Reset
REQ-017 While reset = 0:
- state = IDLE; n, r and latched k are 0; cfg_err = 0.
- Every output is 0 except srt_reset, which SHALL be 1 combinationally.
- Effect is immediate (asynchronous).
REQ-018 Reset asserted mid-query SHALL abandon the query. After release, the next start SHALL pass through CLR before any insert.

Verification
REQ-019 k=3; stream 40,10,30,20 (last on 20) -> results in order (1,10), (3,20), (2,30); out_last on the third; busy falls after its handshake.
REQ-020 k=5; stream 7,3 -> exactly 2 results, (1,3) then (0,7); out_last on the second.
REQ-021 k=2; out_ready held low 4 cycles in READ -> out_name/out_value stable; first result not duplicated or lost; second result appears 3 cycles after the first handshake.
REQ-022 start with k_cfg=0 -> cfg_err=1, busy stays 0; a following start with k_cfg=1 and stream 9 -> single result (0,9); cfg_err remains 1.
REQ-023 reset pulled low during LOAD after 2 accepts -> srt_reset=1 and all other outputs 0 immediately; new query k=1, stream 5 -> result (0,5).
REQ-024 start pulse during READ -> ignored; current query completes unchanged.

Source files
------------

// File: rtl/ksort_ctrl.sv
// rtl/ksort_ctrl.sv - k-nearest query controller: streams values into an external sorter, then reads back the k smallest.
module ksort_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_MEMORY = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           k_cfg,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_name,
  output logic [DATA_WIDTH-1:0] out_value,
  output logic                  out_last,
  output logic                  busy,
  output logic                  cfg_err,
  output logic                  srt_reset,
  output logic                  srt_wr_en,
  output logic                  srt_valid,
  output logic                  srt_rd_en,
  output logic                  srt_done,
  output logic [31:0]           srt_k,
  output logic [DATA_WIDTH-1:0] srt_data,
  input  logic [31:0]           srt_name_in,
  input  logic [DATA_WIDTH-1:0] srt_value_in
);

  localparam logic [31:0] LP_MAX_MEM = 32'(MAX_MEMORY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_READ,
    S_ADV1,
    S_ADV2
  } state_t;

  state_t      r_state;
  logic [31:0] r_k;
  logic [31:0] r_n;
  logic [31:0] r_m;
  logic [31:0] r_r;
  logic        r_cfg_err;

  logic        w_accept;
  logic [31:0] w_n_next;
  logic [31:0] w_min_nk;
  logic [31:0] w_m_next;
  logic        w_read_last;

  assign w_accept    = (r_state == S_LOAD) && in_valid;
  assign w_n_next    = (r_n == 32'hFFFF_FFFF) ? r_n : r_n + 32'd1;
  // The result count must include the value accepted together with in_last.
  assign w_min_nk    = (w_n_next < r_k) ? w_n_next : r_k;
  assign w_m_next    = (w_min_nk < LP_MAX_MEM) ? w_min_nk : LP_MAX_MEM;
  assign w_read_last = (r_r == r_m - 32'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_n       <= '0;
      r_m       <= '0;
      r_r       <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (k_cfg != 32'd0) begin
              r_k     <= k_cfg;
              r_state <= S_CLR;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        S_CLR: begin
          r_n     <= '0;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          if (w_accept) begin
            r_n <= w_n_next;
            if (in_last) begin
              r_m     <= w_m_next;
              r_r     <= '0;
              r_state <= (w_m_next == 32'd0) ? S_IDLE : S_READ;
            end
          end
        end
        S_READ: begin
          if (out_ready) begin
            if (w_read_last) begin
              r_state <= S_IDLE;
            end else begin
              r_r     <= r_r + 32'd1;
              r_state <= S_ADV1;
            end
          end
        end
        // Two read strobes move the sorter pointer by one entry.
        S_ADV1:  r_state <= S_ADV2;
        S_ADV2:  r_state <= S_READ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_LOAD);
  assign srt_wr_en = w_accept;
  assign srt_valid = w_accept;
  assign out_valid = (r_state == S_READ);
  assign out_name  = (r_state == S_READ) ? srt_name_in : '0;
  assign out_value = (r_state == S_READ) ? srt_value_in : '0;
  assign out_last  = (r_state == S_READ) && w_read_last;
  assign busy      = (r_state != S_IDLE);
  assign cfg_err   = r_cfg_err;
  assign srt_reset = !reset || (r_state == S_CLR);
  assign srt_rd_en = (r_state == S_ADV1) || (r_state == S_ADV2);
  assign srt_done  = (r_state == S_READ) || (r_state == S_ADV1) || (r_state == S_ADV2);
  assign srt_k     = r_k;
  assign srt_data  = reset ? in_data : '0;

endmodule

// File: tb/tb_ksort_ctrl.sv
// tb/tb_ksort_ctrl.sv - self-checking bench for ksort_ctrl with a behavioural sorter model.
module tb_ksort_ctrl;

  localparam int DW   = 32;
  localparam int MAXM = 4;
  localparam int SD   = 16;

  logic          clk;
  logic          reset;
  logic          start;
  logic [31:0]   k_cfg;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_name;
  logic [DW-1:0] out_value;
  logic          out_last;
  logic          busy;
  logic          cfg_err;
  logic          srt_reset;
  logic          srt_wr_en;
  logic          srt_valid;
  logic          srt_rd_en;
  logic          srt_done;
  logic [31:0]   srt_k;
  logic [DW-1:0] srt_data;
  logic [31:0]   srt_name_in;
  logic [DW-1:0] srt_value_in;

  ksort_ctrl #(.DATA_WIDTH(DW), .MAX_MEMORY(MAXM)) dut (
    .clk(clk), .reset(reset), .start(start), .k_cfg(k_cfg),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_name(out_name),
    .out_value(out_value), .out_last(out_last), .busy(busy), .cfg_err(cfg_err),
    .srt_reset(srt_reset), .srt_wr_en(srt_wr_en), .srt_valid(srt_valid),
    .srt_rd_en(srt_rd_en), .srt_done(srt_done), .srt_k(srt_k), .srt_data(srt_data),
    .srt_name_in(srt_name_in), .srt_value_in(srt_value_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sorter model: ascending insert, name = arrival index, pointer moves every second read strobe.
  logic [31:0]   s_name [SD];
  logic [DW-1:0] s_val  [SD];
  int            s_cnt;
  logic [3:0]    s_ptr;
  logic          s_half;

  always @(posedge clk) begin : sorter
    int pos;
    if (srt_reset) begin
      s_cnt  <= 0;
      s_ptr  <= '0;
      s_half <= 1'b0;
    end else begin
      if (srt_wr_en && s_cnt < SD) begin
        pos = 0;
        for (int i = 0; i < SD; i++)
          if (i < s_cnt && s_val[i] <= srt_data) pos = i + 1;
        for (int j = 0; j < SD; j++) begin
          if (j == pos) begin
            s_val[j]  <= srt_data;
            s_name[j] <= 32'(s_cnt);
          end else if (j > pos && j <= s_cnt) begin
            s_val[j]  <= s_val[j-1];
            s_name[j] <= s_name[j-1];
          end
        end
        s_cnt <= s_cnt + 1;
      end
      if (srt_rd_en) begin
        s_half <= ~s_half;
        if (s_half) s_ptr <= s_ptr + 4'd1;
      end
    end
  end

  assign srt_name_in  = s_name[s_ptr];
  assign srt_value_in = s_val[s_ptr];

  typedef struct {
    logic [31:0] name;
    logic [31:0] value;
    logic        last;
  } res_t;

  typedef struct {
    int               k;
    int               n;
    logic [0:7][31:0] v;
    int               stall;
    bit               poke_start;
  } vec_t;

  res_t sb[$];
  vec_t vecs[6];
  int   n_checks = 0;
  int   n_err    = 0;
  logic exp_cfg_err;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input int k, input int n, input logic [0:7][31:0] v);
    int ord[8];
    int pos;
    int m;
    res_t e;
    for (int i = 0; i < n; i++) begin
      pos = 0;
      for (int j = 0; j < i; j++)
        if (v[ord[j]] <= v[i]) pos = j + 1;
      for (int j = i; j > pos; j--) ord[j] = ord[j-1];
      ord[pos] = i;
    end
    m = n;
    if (k < m) m = k;
    if (MAXM < m) m = MAXM;
    for (int p = 0; p < m; p++) begin
      e.name  = 32'(ord[p]);
      e.value = v[ord[p]];
      e.last  = (p == m - 1);
      sb.push_back(e);
    end
  endtask

  task automatic drain(input int stall, input bit poke_start);
    bit   first;
    int   waited;
    res_t e;
    first = 1'b1;
    while (sb.size() > 0) begin
      waited = 0;
      while (!out_valid && waited < 10) begin
        step();
        waited++;
      end
      if (!out_valid) begin
        check("out_valid_timeout", 0, 1);
        sb.delete();
        break;
      end
      if (!first) check("result_gap", waited, 2);
      e = sb.pop_front();
      if (first) begin
        for (int s = 0; s < stall; s++) begin
          if (poke_start && s == 0) begin
            start = 1'b1;
            k_cfg = 32'd0;
          end
          step();
          start = 1'b0;
          check("stall_valid", out_valid, 1);
          check("stall_name", out_name, e.name);
          check("stall_value", out_value, e.value);
          check("stall_cfg_err", cfg_err, exp_cfg_err);
        end
      end
      check("out_name", out_name, e.name);
      check("out_value", out_value, e.value);
      check("out_last", out_last, e.last);
      check("read_done", srt_done, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      if (e.last) begin
        check("end_busy", busy, 0);
        check("end_valid", out_valid, 0);
        check("end_done", srt_done, 0);
      end else begin
        check("adv_valid", out_valid, 0);
        check("adv_rd_en", srt_rd_en, 1);
      end
      first = 1'b0;
    end
  endtask

  task automatic run_query(input vec_t t);
    start = 1'b1;
    k_cfg = 32'(t.k);
    step();
    start = 1'b0;
    check("clr_srt_reset", srt_reset, 1);
    check("clr_busy", busy, 1);
    check("clr_srt_k", srt_k, 32'(t.k));
    step();
    push_expected(t.k, t.n, t.v);
    for (int i = 0; i < t.n; i++) begin
      in_valid = 1'b1;
      in_data  = t.v[i];
      in_last  = (i == t.n - 1);
      #1;
      check("load_in_ready", in_ready, 1);
      check("load_wr_en", srt_wr_en, 1);
      check("load_srt_data", srt_data, t.v[i]);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("first_latency", out_valid, 1);
    drain(t.stall, t.poke_start);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t q;
    reset = 1'b0; start = 1'b0; k_cfg = '0; in_valid = 1'b1; in_data = 32'hA5A5_5A5A;
    in_last = 1'b0; out_ready = 1'b0; exp_cfg_err = 1'b0;
    #1;
    check("rst_srt_reset", srt_reset, 1);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_en", srt_wr_en, 0);
    check("rst_srt_data", srt_data, 0);
    check("rst_srt_k", srt_k, 0);
    check("rst_cfg_err", cfg_err, 0);
    step();
    step();
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rel_srt_reset", srt_reset, 0);

    vecs[0].k = 3; vecs[0].n = 4; vecs[0].v = '{40, 10, 30, 20, 0, 0, 0, 0};
    vecs[0].stall = 0; vecs[0].poke_start = 0;
    vecs[1].k = 5; vecs[1].n = 2; vecs[1].v = '{7, 3, 0, 0, 0, 0, 0, 0};
    vecs[1].stall = 0; vecs[1].poke_start = 0;
    vecs[2].k = 2; vecs[2].n = 3; vecs[2].v = '{50, 20, 60, 0, 0, 0, 0, 0};
    vecs[2].stall = 4; vecs[2].poke_start = 0;
    vecs[3].k = 6; vecs[3].n = 8; vecs[3].v = '{8, 7, 6, 5, 4, 3, 2, 1};
    vecs[3].stall = 0; vecs[3].poke_start = 0;
    vecs[4].k = 4; vecs[4].n = 4; vecs[4].v = '{5, 5, 1, 5, 0, 0, 0, 0};
    vecs[4].stall = 0; vecs[4].poke_start = 0;
    vecs[5].k = 3; vecs[5].n = 3; vecs[5].v = '{300, 100, 200, 0, 0, 0, 0, 0};
    vecs[5].stall = 2; vecs[5].poke_start = 1;

    for (int i = 0; i < 6; i++) run_query(vecs[i]);

    start = 1'b1;
    k_cfg = 32'd0;
    step();
    start = 1'b0;
    exp_cfg_err = 1'b1;
    check("cfg_err_set", cfg_err, 1);
    check("cfg_err_busy", busy, 0);
    step();
    check("cfg_err_idle", busy, 0);
    q.k = 1; q.n = 1; q.v = '{9, 0, 0, 0, 0, 0, 0, 0}; q.stall = 0; q.poke_start = 0;
    run_query(q);
    check("cfg_err_sticky", cfg_err, 1);

    start = 1'b1;
    k_cfg = 32'd3;
    step();
    start = 1'b0;
    step();
    in_valid = 1'b1;
    in_data  = 32'd11;
    step();
    in_data  = 32'd12;
    step();
    in_data  = 32'd13;
    reset = 1'b0;
    #1;
    exp_cfg_err = 1'b0;
    check("mid_srt_reset", srt_reset, 1);
    check("mid_in_ready", in_ready, 0);
    check("mid_wr_en", srt_wr_en, 0);
    check("mid_valid", srt_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_cfg_err", cfg_err, 0);
    check("mid_srt_k", srt_k, 0);
    check("mid_srt_data", srt_data, 0);
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    q.k = 1; q.n = 1; q.v = '{5, 0, 0, 0, 0, 0, 0, 0};
    run_query(q);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
